// File: rtl/filter_phase_sequencer_pkg.sv
// Shared types and constants for the cochlea filter phase sequencer.
// Holds the FSM state encoding, the minimum dead time and the default field widths.
package filter_phase_sequencer_pkg;

  localparam int DEF_DIV_W  = 8;
  localparam int DEF_DEAD_W = 4;
  localparam int DEF_CNT_W  = 16;

  // A gap of at least two clocks lets the 2-flop synchronizers settle before capture.
  localparam int MIN_DEAD = 2;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    GAP1,
    PH2,
    GAP2
  } state_t;

endpackage

// File: rtl/filter_phase_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous comparator outputs of the macro.
// Cleared by the sequencer's asynchronous active-low reset.
module sync2
  import filter_phase_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/filter_phase_sequencer.sv
// Non-overlapping two-phase clock generator for the switched-capacitor filter macro,
// with once-per-frame comparator sampling and a single-entry valid/ready event output.
module filter_phase_sequencer
  import filter_phase_sequencer_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int DEAD_W = DEF_DEAD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  half_period,
  input  logic [DEAD_W-1:0] dead_time,
  output logic              phi1,
  output logic              phi2,
  output logic              phi1b,
  output logic              phi2b,
  input  logic              compout,
  input  logic              pol,
  input  logic              polxevent,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_pol,
  output logic              ev_comp,
  output logic [CNT_W-1:0]  ev_stamp,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  localparam int PW = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;
  localparam logic [PW-1:0]     CNT_ONE   = PW'(1);
  localparam logic [DEAD_W-1:0] MIN_DT    = DEAD_W'(MIN_DEAD);
  localparam logic [CNT_W-1:0]  FRAME_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DROP_MAX  = '1;

  state_t            state;
  logic [PW-1:0]     cnt;
  logic [DIV_W-1:0]  hp;
  logic [DEAD_W-1:0] dt;
  logic [CNT_W-1:0]  frame_cnt;
  logic [DEAD_W-1:0] dead_min;
  logic              comp_s;
  logic              pol_s;
  logic              px_s;
  logic              cnt_done;
  logic              last_gap2;
  logic              start;

  sync2 u_sync_comp (.clk(wb_clk_i), .rst_n(wb_rst_n), .d(compout),   .q(comp_s));
  sync2 u_sync_pol  (.clk(wb_clk_i), .rst_n(wb_rst_n), .d(pol),       .q(pol_s));
  sync2 u_sync_px   (.clk(wb_clk_i), .rst_n(wb_rst_n), .d(polxevent), .q(px_s));

  assign cnt_done  = (cnt == '0);
  assign last_gap2 = (state == GAP2) && cnt_done;
  assign start     = enable && ((state == IDLE) || last_gap2);
  assign dead_min  = (dead_time < MIN_DT) ? MIN_DT : dead_time;

  // cnt counts down the remaining clocks of the current phase or gap; a new
  // frame (from IDLE or straight out of GAP2) overrides whatever the case chose.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hp    <= '0;
      dt    <= MIN_DT;
      phi1  <= 1'b0;
      phi2  <= 1'b0;
      phi1b <= 1'b1;
      phi2b <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
        end
        PH1: begin
          if (cnt_done) begin
            state <= GAP1;
            phi1  <= 1'b0;
            phi1b <= 1'b1;
            cnt   <= PW'(dt) - CNT_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP1: begin
          if (cnt_done) begin
            state <= PH2;
            phi2  <= 1'b1;
            phi2b <= 1'b0;
            cnt   <= PW'(hp);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        PH2: begin
          if (cnt_done) begin
            state <= GAP2;
            phi2  <= 1'b0;
            phi2b <= 1'b1;
            cnt   <= PW'(dt) - CNT_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP2: begin
          if (cnt_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          phi1  <= 1'b0;
          phi2  <= 1'b0;
          phi1b <= 1'b1;
          phi2b <= 1'b1;
          busy  <= 1'b0;
        end
      endcase

      if (start) begin
        state <= PH1;
        hp    <= half_period;
        dt    <= dead_min;
        cnt   <= PW'(half_period);
        phi1  <= 1'b1;
        phi1b <= 1'b0;
        busy  <= 1'b1;
      end
    end
  end

  // Capture at the end of GAP2; a load may coincide with the consumer's accept.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ev_valid  <= 1'b0;
      ev_pol    <= 1'b0;
      ev_comp   <= 1'b0;
      ev_stamp  <= '0;
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
      if (last_gap2) begin
        frame_cnt <= frame_cnt + FRAME_ONE;
        if (px_s) begin
          if (!ev_valid || ev_ready) begin
            ev_valid <= 1'b1;
            ev_pol   <= pol_s;
            ev_comp  <= comp_s;
            ev_stamp <= frame_cnt;
          end else if (drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + FRAME_ONE;
          end
        end
      end
    end
  end

endmodule

// File: doc/filter_phase_sequencer.md
Name: filter_phase_sequencer

Overview:
- Drives the switched-capacitor cochlea filter/comparator macro (filter_p_m_fin).
- Generates its non-overlapping two-phase clocks (phi1, phi2, phi1b, phi2b) from the digital clock, with programmable phase length and dead time.
- Samples the macro's comparator outputs once per frame and forwards event frames over a single-entry valid/ready interface. Sits between the macro and the digital event logic.

Parameters:
- DIV_W, 8, width of the phase-length field.
- DEAD_W, 4, width of the dead-time field.
- CNT_W, 16, width of the frame counter, timestamp and drop counter.

Ports:
- wb_clk_i  in  1  digital clock; the only clock.
- wb_rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- half_period  in  DIV_W  phase high time, in clocks, minus 1.
- dead_time  in  DEAD_W  non-overlap gap, in clocks.
- phi1, phi2  out  1  macro phase clocks.
- phi1b, phi2b  out  1  complements of phi1, phi2.
- compout, pol, polxevent  in  1 each  macro outputs; asynchronous to wb_clk_i.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_pol  out  1  sampled polarity.
- ev_comp  out  1  sampled compout.
- ev_stamp  out  CNT_W  frame number of the event.
- drop_cnt  out  CNT_W  saturating count of lost events.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, wb_rst_n=0):
  - phi1=phi2=0, phi1b=phi2b=1.
  - ev_valid=0; ev_pol=ev_comp=0; ev_stamp=0; drop_cnt=0; busy=0.
  - Frame counter=0. FSM=IDLE. Synchronizers cleared.
- Phase outputs are registered. phi1b is exactly ~phi1 and phi2b is exactly ~phi2 every cycle. phi1 and phi2 are never high in the same cycle.
- FSM states: IDLE -> PH1 -> GAP1 -> PH2 -> GAP2 -> (PH1 | IDLE).
  - IDLE: all phases low. Go to PH1 on enable=1.
  - On each entry to PH1, latch the config: hp=half_period, dt=max(dead_time,2). Config changes mid-frame have no effect until the next frame.
  - PH1 and PH2 each last hp+1 clocks, with phi1 or phi2 high respectively.
  - GAP1 and GAP2 each last dt clocks, with both phases low.
  - Frame length = 2*(hp+1) + 2*dt clocks.
- enable=0 during a frame: the frame completes through GAP2, then the FSM goes to IDLE. No truncated phase pulse is ever produced. enable=1 at the GAP2 exit starts the next frame immediately.
- Sampling:
  - compout, pol and polxevent each pass through a 2-flop synchronizer.
  - On the last cycle of GAP2, the synchronized values are captured. The minimum dt of 2 guarantees the capture reflects the macro's state at the end of phi2.
  - The frame counter increments (wrapping) at the same edge. ev_stamp carries the pre-increment frame counter value.
- Event output:
  - If captured polxevent=1, an event is generated with ev_pol, ev_comp and ev_stamp.
  - The output register loads when it is empty, or when ev_valid=1 and ev_ready=1 in that same cycle; the accept and the load happen together.
  - If ev_valid=1 and ev_ready=0 when an event arrives, the held event is kept. The new event is dropped and drop_cnt increments, saturating at all-ones.
  - ev_valid falls one cycle after a handshake, unless a new load occurs.
  - ev_* are stable while ev_valid=1 and ev_ready=0.
- If captured polxevent=0, no event is generated and the output register is unchanged.
- Reset asserted mid-frame: phases drop immediately and the pending event is lost.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, PH1, GAP1, PH2, GAP2.
  - MIN_DEAD=2.
  - Default widths DIV_W, DEAD_W, CNT_W.
- One natural sub-module: sync2, the 2-flop synchronizer, instantiated 3x.

Test Plan:
- Reset, then enable=1, half_period=3, dead_time=2 -> phi1 high 4 clk, gap 2, phi2 high 4 clk, gap 2; period 12 clk; phi1b/phi2b complementary; no overlap (checked by assertion).
- dead_time=0 -> gaps are 2 clk. Change half_period from 3 to 7 mid-PH2 -> current frame unchanged; next PH1 lasts 8 clk.
- polxevent=1, pol=1 held over frame 5, ev_ready=1 -> ev_valid pulses once with ev_pol=1, ev_stamp=5.
- ev_ready=0, polxevent=1 for 3 frames -> first event held with stamp intact; drop_cnt=2. ev_ready=1 then -> handshake completes and ev_valid drops.
- Handshake in the same cycle a new event loads -> ev_valid stays 1 with the new stamp; drop_cnt unchanged.
- enable=0 mid-PH1 -> frame completes through GAP2, then IDLE with busy=0. Separately, wb_rst_n=0 mid-PH2 -> phi2=0 and phi2b=1 asynchronously; counters cleared.
